spi_xfer_seq: RTL and testbench
===============================

// Module: spi_xfer_seq
// PURPOSE
//  Multi-byte SPI transaction sequencer; sits directly upstream of the byte-level SPI master.
//  Accepts a start command with a byte count and pulls TX bytes from a valid/ready stream.
//  Drives cs_ctrl, wr_req and data_tx into the master, and returns each data_rx byte as a one-cycle pulse.
//  Enforces CS setup, hold and minimum-deassert timing in sys_clk cycles.
// PARAMETERS
//  LEN_W     8   width of len; max burst = 2**LEN_W-1 bytes
//  CS_SETUP  4   cycles cs_ctrl low before first wr_req (>=1)
//  CS_HOLD   4   cycles cs_ctrl held low after last wr_ack (>=1)
//  CS_IDLE   2   min cycles cs_ctrl high before done / next start (>=1)
// PORTS
//  sys_clk     in   1      clock, all logic rising-edge
//  sys_rst     in   1      synchronous, active-high reset
//  start       in   1      begin transaction; sampled only in IDLE
//  len         in   LEN_W  byte count, latched with start
//  abort       in   1      end transaction early (see BEHAVIOUR)
//  busy        out  1      state != IDLE
//  done        out  1      1-cycle pulse, transaction complete
//  aborted     out  1      valid with done: 1 = ended by abort
//  tx_data     in   8      next byte to send
//  tx_valid    in   1      tx_data valid
//  tx_ready    out  1      = (state==LOAD); byte taken on tx_valid&tx_ready
//  rx_data     out  8      byte received from master
//  rx_valid    out  1      1-cycle pulse, rx_data valid
//  cs_ctrl     out  1      to master cs_ctrl, active-low chip select
//  wr_req      out  1      to master byte request
//  data_tx     out  8      to master byte to send
//  wr_ack      in   1      from master, 1-cycle byte-done strobe
//  data_rx     in   8      from master, valid while wr_ack=1
// BEHAVIOUR
//  Reset values: state=IDLE, cs_ctrl=1, wr_req=0, data_tx=0, rx_data=0, rx_valid=0.
//  Reset values (cont.): done=0, aborted=0, byte count=0.
//  Reset is effective at any state, mid-transaction included; no done is generated.
//  sys_rst must be applied together with the master's reset so no byte is left in flight.
//  IDLE: start=1 & len!=0 -> latch len; cs_ctrl<=0; go SETUP.
//  IDLE: start=1 & len==0 -> done=1 next cycle, cs_ctrl stays 1, aborted=0.
//  SETUP: count CS_SETUP cycles, then go LOAD.
//  LOAD: tx_ready=1; on tx_valid -> data_tx<=tx_data, wr_req<=1, go REQ.
//  LOAD: tx underflow simply waits here, cs_ctrl held low.
//  REQ: wr_req held 1 until wr_ack=1; on that edge wr_req<=0, rx_data<=data_rx, rx_valid<=1, count+1.
//  REQ (cont.): then go GAP.
//  wr_req must be 0 before the master's FINISH->IDLE return so it cannot re-trigger.
//  GAP: exactly 1 cycle; go HOLD if count==len, else go LOAD.
//  HOLD: count CS_HOLD cycles with cs_ctrl=0; then cs_ctrl<=1, go DESEL.
//  DESEL: count CS_IDLE cycles; on exit done=1 for one cycle, state=IDLE.
//  busy falls the same cycle done rises.
//  start while busy: ignored, no queuing.
//  abort in SETUP or LOAD -> go HOLD next cycle; no byte is consumed.
//  abort in REQ or GAP -> current byte completes and its rx_valid is still issued, then HOLD.
//  aborted=1 is latched, presented with done, and cleared on the next accepted start.
//  abort in HOLD, DESEL or IDLE: no effect.
//  Byte counter is LEN_W bits; delay counters are $clog2(max+1) bits and reload on every state entry.
//  Per-byte overhead: 1 cycle LOAD (tx_valid ready) + 1 cycle GAP beyond the master's own latency.
// TESTING
//  T1 len=3, tx bytes A5,3C,FF always valid, master model loops miso<=mosi:
//     -> 3 wr_req/ack pairs; rx_valid x3 with A5,3C,FF; cs low for the whole burst; one done, aborted=0.
//  T2 CS timing, defaults -> first wr_req exactly 4 cycles after cs falls; cs rises 4 cycles after the last
//     GAP; done 2 cycles after cs rises.
//  T3 len=0 -> done the cycle after start; cs_ctrl, wr_req, tx_ready never asserted.
//  T4 len=2, tx_valid held 0 for 20 cycles before byte 2 -> cs stays low, wr_req stays 0 and tx_ready
//     stays 1 throughout the stall; byte 2 then completes normally.
//  T5 len=5, abort pulsed mid-byte 2 -> byte 2 rx_valid issued, no byte 3 request, done with aborted=1.
//  T5b abort during SETUP -> no wr_req at all, done with aborted=1.
//  T6 sys_rst pulsed during REQ -> next cycle cs_ctrl=1, wr_req=0, busy=0, no done.
//  T6b start pulsed while busy -> ignored; transaction count is unchanged.

Source files
------------

// File: rtl/spi_xfer_seq.sv
// Multi-byte SPI transaction sequencer in front of a byte-level master; enforces CS setup/hold/idle in clk cycles.
// Per byte: 1 LOAD + master latency + 1 GAP; a stalled tx stream parks in LOAD with CS held low.
module spi_xfer_seq #(
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             cs_ctrl,
  output logic             wr_req,
  output logic [7:0]       data_tx,
  input  logic             wr_ack,
  input  logic [7:0]       data_rx
);

  localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_DLY = (MAX_SH > CS_IDLE) ? MAX_SH : CS_IDLE;
  localparam int DW      = $clog2(MAX_DLY + 1);
  // The LOAD cycle ahead of the first wr_req is part of the setup window, so SETUP itself runs one short.
  localparam int SETUP_LAST = (CS_SETUP > 1) ? CS_SETUP - 2 : 0;
  localparam logic [DW-1:0] SETUP_END = DW'(SETUP_LAST);
  localparam logic [DW-1:0] HOLD_END  = DW'(CS_HOLD - 1);
  localparam logic [DW-1:0] IDLE_END  = DW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_REQ, S_GAP, S_HOLD, S_DESEL
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    dly;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             timed;

  assign timed = (state == S_SETUP) || (state == S_HOLD) || (state == S_DESEL);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && (len != '0)) state_nxt = (CS_SETUP > 1) ? S_SETUP : S_LOAD;
      S_SETUP: if (abort) state_nxt = S_HOLD;
               else if (dly == SETUP_END) state_nxt = S_LOAD;
      S_LOAD:  if (abort) state_nxt = S_HOLD;
               else if (tx_valid) state_nxt = S_REQ;
      S_REQ:   if (wr_ack) state_nxt = S_GAP;
      S_GAP:   state_nxt = (abort || aborted || (cnt == len_q)) ? S_HOLD : S_LOAD;
      S_HOLD:  if (dly == HOLD_END) state_nxt = S_DESEL;
      S_DESEL: if (dly == IDLE_END) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    tx_ready = (state == S_LOAD) && !abort;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dly      <= '0;
      len_q    <= '0;
      cnt      <= '0;
      cs_ctrl  <= 1'b1;
      wr_req   <= 1'b0;
      data_tx  <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      if (state_nxt != state) dly <= '0;
      else if (timed)         dly <= dly + DW'(1);
      case (state)
        S_IDLE: if (start) begin
          aborted <= 1'b0;
          if (len == '0) begin
            done <= 1'b1;
          end else begin
            len_q   <= len;
            cnt     <= '0;
            cs_ctrl <= 1'b0;
          end
        end
        S_LOAD: if (tx_valid && tx_ready) begin
          data_tx <= tx_data;
          wr_req  <= 1'b1;
        end
        // wr_req drops on the ack edge so the master cannot see it again on its return to idle.
        S_REQ: if (wr_ack) begin
          wr_req   <= 1'b0;
          rx_data  <= data_rx;
          rx_valid <= 1'b1;
          cnt      <= cnt + LEN_W'(1);
        end
        S_HOLD:  if (state_nxt == S_DESEL) cs_ctrl <= 1'b1;
        S_DESEL: if (state_nxt == S_IDLE)  done <= 1'b1;
        default: ;
      endcase
      if (abort && ((state == S_SETUP) || (state == S_LOAD) || (state == S_REQ) || (state == S_GAP)))
        aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: looped-back byte master, table of transactions, scoreboard of returned bytes.
module tb_spi_xfer_seq;

  localparam int M_LAT = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       busy, done, aborted;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cs_ctrl, wr_req;
  logic [7:0] data_tx;
  logic       wr_ack  = 1'b0;
  logic [7:0] data_rx = 8'h00;
  logic       hs      = 1'b0;
  int         lat     = 0;

  int total = 0;
  int bad   = 0;
  logic [7:0] txq[$];
  logic [7:0] exp_q[$];
  int n_taken;
  int stall_left;

  typedef struct {
    int len; int stall; int abort_kind; int restart; int rot;
    int exp_req; int exp_rx; int exp_abt; int exp_stall; int exp_lat;
  } vec_t;

  spi_xfer_seq dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .cs_ctrl(cs_ctrl), .wr_req(wr_req), .data_tx(data_tx),
    .wr_ack(wr_ack), .data_rx(data_rx)
  );

  always #5 sys_clk = ~sys_clk;

  // Byte master: acks M_LAT negedges after seeing wr_req, echoing the sent byte back.
  always @(negedge sys_clk) begin
    if (sys_rst || wr_ack) begin
      wr_ack = 1'b0;
      lat    = 0;
    end else if (wr_req) begin
      if (lat == M_LAT - 1) begin
        wr_ack  = 1'b1;
        data_rx = data_tx;
      end else begin
        lat++;
      end
    end
  end

  always @(posedge sys_clk) hs <= tx_valid && tx_ready && !sys_rst;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: wait past the falling edge, retire any accepted byte, then present the next one.
  task automatic step();
    @(negedge sys_clk);
    #1;
    if (hs) begin
      exp_q.push_back(txq.pop_front());
      n_taken++;
    end
    if (n_taken == 1 && stall_left > 0) begin
      tx_valid = 1'b0;
      stall_left--;
    end else begin
      tx_valid = (txq.size() > 0);
      if (txq.size() > 0) tx_data = txq[0];
    end
  endtask

  task automatic run_row(input int r, input vec_t v);
    logic [7:0] pat [8];
    int nreq, nrx, nstall, viol, ncsrise, nlowcs, t_fall, t_req, t_rx, t_rise, t_done;
    int got_abt, busy_at_done, post_done;
    logic abt_sent, pw, pc;
    pat = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h5A, 8'hC3};
    for (int i = 0; i < v.len; i++) txq.push_back(pat[(i + v.rot) % 8]);
    n_taken = 0; stall_left = v.stall;
    nreq = 0; nrx = 0; nstall = 0; viol = 0; ncsrise = 0; nlowcs = 0;
    t_fall = -1; t_req = -1; t_rx = -1; t_rise = -1; t_done = -1;
    got_abt = -1; busy_at_done = -1; abt_sent = 1'b0; pw = wr_req; pc = cs_ctrl;
    len = 8'(v.len);
    start = 1'b1;
    for (int c = 1; c <= 500; c++) begin
      step();
      if (wr_req && !pw) begin
        nreq++;
        if (nreq == 1) t_req = c;
        if (cs_ctrl) viol++;
      end
      if (!cs_ctrl) nlowcs++;
      if (!cs_ctrl && t_fall < 0) t_fall = c;
      if (cs_ctrl && !pc) begin ncsrise++; t_rise = c; end
      if (rx_valid) begin
        nrx++;
        t_rx = c;
        if (exp_q.size() == 0) chk($sformatf("r%0d rx_unexpected", r), int'(rx_data), -1);
        else chk($sformatf("r%0d rx_data", r), int'(rx_data), int'(exp_q.pop_front()));
      end
      if (tx_ready && !tx_valid) begin
        nstall++;
        if (cs_ctrl || wr_req) viol++;
      end
      pw = wr_req; pc = cs_ctrl;
      if (done) begin
        t_done = c; got_abt = int'(aborted); busy_at_done = int'(busy);
        break;
      end
      start = (v.restart != 0) && (c == 6);
      if (c == 6 && v.restart != 0) len = 8'd5;
      abort = ((v.abort_kind == 1) && (c == 1)) || ((v.abort_kind == 2) && (nreq == 2) && !abt_sent);
      if (abort) abt_sent = 1'b1;
    end
    start = 1'b0; abort = 1'b0;
    chk($sformatf("r%0d done_seen", r), int'(t_done >= 0), 1);
    chk($sformatf("r%0d done_latency", r), t_done, v.exp_lat);
    chk($sformatf("r%0d wr_req_count", r), nreq, v.exp_req);
    chk($sformatf("r%0d rx_count", r), nrx, v.exp_rx);
    chk($sformatf("r%0d aborted", r), got_abt, v.exp_abt);
    chk($sformatf("r%0d stall_cycles", r), nstall, v.exp_stall);
    chk($sformatf("r%0d cs_violations", r), viol, 0);
    chk($sformatf("r%0d busy_at_done", r), busy_at_done, 0);
    chk($sformatf("r%0d cs_rises", r), ncsrise, (v.len > 0) ? 1 : 0);
    if (v.len == 0) chk($sformatf("r%0d cs_low_cycles", r), nlowcs, 0);
    if (nreq > 0) chk($sformatf("r%0d cs_to_req", r), t_req - t_fall, 4);
    if (v.abort_kind == 0 && v.len > 0) chk($sformatf("r%0d last_rx_to_cs_rise", r), t_rise - t_rx, 5);
    if (ncsrise > 0) chk($sformatf("r%0d cs_rise_to_done", r), t_done - t_rise, 2);
    chk($sformatf("r%0d scoreboard_left", r), exp_q.size(), 0);
    post_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) post_done++;
    end
    chk($sformatf("r%0d quiet_after_done", r), post_done, 0);
    txq.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs [8];
    int   got_req, extra;
    //        len stall abk rst rot  req rx abt stall lat
    vecs[0] = '{3,  0,   0,  0,  0,   3,  3, 0,  0,   25};
    vecs[1] = '{0,  0,   0,  0,  1,   0,  0, 0,  0,   1};
    vecs[2] = '{2,  20,  0,  0,  2,   2,  2, 0,  16,  36};
    vecs[3] = '{5,  0,   2,  0,  3,   2,  2, 1,  0,   20};
    vecs[4] = '{4,  0,   1,  0,  4,   0,  0, 1,  0,   8};
    vecs[5] = '{2,  0,   0,  1,  5,   2,  2, 0,  0,   20};
    vecs[6] = '{1,  0,   0,  0,  6,   1,  1, 0,  0,   15};
    vecs[7] = '{6,  0,   0,  0,  7,   6,  6, 0,  0,   40};

    sys_rst = 1'b1; start = 1'b0; len = 8'd0; abort = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; n_taken = 0; stall_left = 0;
    repeat (3) step();
    sys_rst = 1'b0;
    step();
    chk("rst cs_ctrl", int'(cs_ctrl), 1);
    chk("rst wr_req", int'(wr_req), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst aborted", int'(aborted), 0);
    chk("rst rx_valid", int'(rx_valid), 0);
    chk("rst tx_ready", int'(tx_ready), 0);
    chk("rst data_tx", int'(data_tx), 0);
    chk("rst rx_data", int'(rx_data), 0);

    foreach (vecs[i]) run_row(i, vecs[i]);

    // Reset landing in the middle of a byte request.
    txq = '{8'h11, 8'h22, 8'h33};
    n_taken = 0; stall_left = 0; got_req = 0;
    len = 8'd3; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      start = 1'b0;
      if (wr_req) begin got_req = 1; break; end
    end
    chk("mid_rst reached_req", got_req, 1);
    sys_rst = 1'b1;
    step();
    chk("mid_rst cs_ctrl", int'(cs_ctrl), 1);
    chk("mid_rst wr_req", int'(wr_req), 0);
    chk("mid_rst busy", int'(busy), 0);
    sys_rst = 1'b0;
    txq.delete(); exp_q.delete(); n_taken = 0;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done || busy || rx_valid) extra++;
    end
    chk("mid_rst quiet", extra, 0);
    exp_q.delete();

    run_row(8, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
